// File: rtl/risc_ex_stage.sv
`default_nettype none
// ============================================================================
// risc_ex_stage : EX stage of the 4-stage RISC pipeline (ALU, branch, dmem, shifter)
// BARREL_SHIFT_EN : single-cycle barrel shifter replaces the iterative shift FSM
// Revision      : 1.0
// ============================================================================
module risc_ex_stage #(
   parameter int DW = 32,
   parameter int SW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] DOF_EX_PC,
   input  logic [DW-1:0] DOF_EX_Bus_A,
   input  logic [DW-1:0] DOF_EX_Bus_B,
   input  logic [SW-1:0] DOF_EX_SH,
   input  logic [4:0]    DOF_EX_FS,
   input  logic [1:0]    DOF_EX_BS,
   input  logic          DOF_EX_PS,
   input  logic          DOF_EX_MW,
   input  logic          DOF_EX_RW,
   input  logic [4:0]    DOF_EX_DA,
   input  logic [2:0]    DOF_EX_MD,
   output logic          EX_stall,
   output logic [DW-1:0] EX_IF_BrA,
   output logic          EX_IF_BrTaken,
   output logic [DW-1:0] EX_MEM_Addr,
   output logic [DW-1:0] EX_MEM_WData,
   output logic          EX_MEM_WE,
   output logic          EX_WB_RW,
   output logic [4:0]    EX_WB_DA,
   output logic [2:0]    EX_WB_MD,
   output logic [DW-1:0] EX_WB_F,
   output logic          EX_WB_NxorV
);

   logic          is_shift;
   logic [DW-1:0] alu_y;
   logic [DW-1:0] alu_sum;
   logic [DW-1:0] alu_f;
   logic          alu_cin;
   logic          alu_arith;
   logic          alu_v;
   logic [DW-1:0] shift_f;
   logic          stall;
   logic          bubble;
   logic          in_shift;
   logic          br_cond;
   logic          br_taken;

   logic          wb_rw_d,    wb_rw_q;
   logic [4:0]    wb_da_d,    wb_da_q;
   logic [2:0]    wb_md_d,    wb_md_q;
   logic [DW-1:0] wb_f_d,     wb_f_q;
   logic          wb_nxorv_d, wb_nxorv_q;

   function automatic logic [DW-1:0] shift_one(input logic [DW-1:0] x, input logic right);
      return right ? {1'b0, x[DW-1:1]} : {x[DW-2:0], 1'b0};
   endfunction

   assign is_shift = (DOF_EX_FS[4:1] == 4'b1000);

   // All add/sub codes share one adder: A + y + cin
   always_comb begin
      alu_y     = '0;
      alu_cin   = 1'b0;
      alu_arith = 1'b1;
      case (DOF_EX_FS)
         5'b00000, 5'b00111: begin end
         5'b00001: alu_cin = 1'b1;
         5'b00010: alu_y = DOF_EX_Bus_B;
         5'b00011: begin alu_y = DOF_EX_Bus_B;  alu_cin = 1'b1; end
         5'b00100: alu_y = ~DOF_EX_Bus_B;
         5'b00101: begin alu_y = ~DOF_EX_Bus_B; alu_cin = 1'b1; end
         5'b00110: alu_y = '1;
         default:  alu_arith = 1'b0;
      endcase
   end

   assign alu_sum = DOF_EX_Bus_A + alu_y + {{(DW-1){1'b0}}, alu_cin};
   assign alu_v   = alu_arith & (DOF_EX_Bus_A[DW-1] == alu_y[DW-1])
                              & (alu_sum[DW-1] != DOF_EX_Bus_A[DW-1]);

   always_comb begin
      alu_f = alu_arith ? alu_sum : '0;
      case (DOF_EX_FS)
         5'b01000: alu_f = DOF_EX_Bus_A & DOF_EX_Bus_B;
         5'b01010: alu_f = DOF_EX_Bus_A | DOF_EX_Bus_B;
         5'b01100: alu_f = DOF_EX_Bus_A ^ DOF_EX_Bus_B;
         5'b01110: alu_f = ~DOF_EX_Bus_A;
         default:  begin end
      endcase
   end

`ifdef BARREL_SHIFT_EN
   assign shift_f  = DOF_EX_FS[0] ? (DOF_EX_Bus_A >> DOF_EX_SH) : (DOF_EX_Bus_A << DOF_EX_SH);
   assign stall    = 1'b0;
   assign bubble   = 1'b0;
   assign in_shift = 1'b0;
`else
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] sh_q,    sh_d;
   logic [SW-1:0] cnt_q,   cnt_d;

   // The IDLE cycle already performs the first shift, so SH=n costs n cycles.
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      bubble  = 1'b0;
      shift_f = (DOF_EX_SH == '0) ? DOF_EX_Bus_A : shift_one(DOF_EX_Bus_A, DOF_EX_FS[0]);
      case (state_q)
         IDLE: begin
            if (is_shift && (DOF_EX_SH > SW'(1))) begin
               stall   = 1'b1;
               bubble  = 1'b1;
               state_d = SHIFT;
               sh_d    = shift_one(DOF_EX_Bus_A, DOF_EX_FS[0]);
               cnt_d   = DOF_EX_SH - SW'(1);
            end
         end
         SHIFT: begin
            sh_d    = shift_one(sh_q, DOF_EX_FS[0]);
            cnt_d   = cnt_q - SW'(1);
            shift_f = sh_d;
            if (cnt_q > SW'(1)) begin
               stall  = 1'b1;
               bubble = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_shift = (state_q == SHIFT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
      end
   end
`endif

   // While reset is held the FSM is idle, so a shift still on the inputs must not stall
   assign EX_stall     = stall & reset;
   assign EX_MEM_Addr  = DOF_EX_Bus_A;
   assign EX_MEM_WData = DOF_EX_Bus_B;
   assign EX_MEM_WE    = DOF_EX_MW & ~EX_stall & ~in_shift;

   assign br_cond = (DOF_EX_Bus_A == '0) ^ DOF_EX_PS;

   always_comb begin
      br_taken = 1'b0;
      case (DOF_EX_BS)
         2'b01:        br_taken = br_cond;
         2'b10, 2'b11: br_taken = 1'b1;
         default:      br_taken = 1'b0;
      endcase
   end

   assign EX_IF_BrA     = (DOF_EX_BS == 2'b10) ? DOF_EX_Bus_A : (DOF_EX_PC + DOF_EX_Bus_B);
   assign EX_IF_BrTaken = br_taken & ~in_shift;

   always_comb begin
      wb_rw_d    = 1'b0;
      wb_da_d    = '0;
      wb_md_d    = '0;
      wb_f_d     = '0;
      wb_nxorv_d = 1'b0;
      if (!bubble) begin
         wb_rw_d    = DOF_EX_RW;
         wb_da_d    = DOF_EX_DA;
         wb_md_d    = DOF_EX_MD;
         wb_f_d     = is_shift ? shift_f : alu_f;
         wb_nxorv_d = wb_f_d[DW-1] ^ alu_v;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_rw_q    <= 1'b0;
         wb_da_q    <= '0;
         wb_md_q    <= '0;
         wb_f_q     <= '0;
         wb_nxorv_q <= 1'b0;
      end else begin
         wb_rw_q    <= wb_rw_d;
         wb_da_q    <= wb_da_d;
         wb_md_q    <= wb_md_d;
         wb_f_q     <= wb_f_d;
         wb_nxorv_q <= wb_nxorv_d;
      end
   end

   assign EX_WB_RW    = wb_rw_q;
   assign EX_WB_DA    = wb_da_q;
   assign EX_WB_MD    = wb_md_q;
   assign EX_WB_F     = wb_f_q;
   assign EX_WB_NxorV = wb_nxorv_q;

endmodule
`default_nettype wire
